// File: rtl/alu_hilo.sv
// Combinational MIPS-style ALU with HI/LO next-state outputs for multiply/divide/move.
// Holds no state: CLK and RESET exist only for pipeline-uniform wiring.
module alu_hilo (
   input  logic        CLK,
   input  logic        RESET,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic [5:0]  ALU_control,
   input  logic [4:0]  shiftAmount,
   input  logic [31:0] HI_IN,
   input  logic [31:0] LO_IN,
   output logic [31:0] aluResult,
   output logic [31:0] HI_OUT,
   output logic [31:0] LO_OUT
);

   localparam logic [5:0] OP_ADD   = 6'h00;
   localparam logic [5:0] OP_ADDU  = 6'h01;
   localparam logic [5:0] OP_SUB   = 6'h02;
   localparam logic [5:0] OP_SUBU  = 6'h03;
   localparam logic [5:0] OP_AND   = 6'h04;
   localparam logic [5:0] OP_OR    = 6'h05;
   localparam logic [5:0] OP_XOR   = 6'h06;
   localparam logic [5:0] OP_NOR   = 6'h07;
   localparam logic [5:0] OP_SLT   = 6'h08;
   localparam logic [5:0] OP_SLTU  = 6'h09;
   localparam logic [5:0] OP_SLL   = 6'h0A;
   localparam logic [5:0] OP_SRL   = 6'h0B;
   localparam logic [5:0] OP_SRA   = 6'h0C;
   localparam logic [5:0] OP_SLLV  = 6'h0D;
   localparam logic [5:0] OP_SRLV  = 6'h0E;
   localparam logic [5:0] OP_SRAV  = 6'h0F;
   localparam logic [5:0] OP_LUI   = 6'h10;
   localparam logic [5:0] OP_MULT  = 6'h11;
   localparam logic [5:0] OP_MULTU = 6'h12;
   localparam logic [5:0] OP_DIV   = 6'h13;
   localparam logic [5:0] OP_DIVU  = 6'h14;
   localparam logic [5:0] OP_MFHI  = 6'h15;
   localparam logic [5:0] OP_MFLO  = 6'h16;
   localparam logic [5:0] OP_MTHI  = 6'h17;
   localparam logic [5:0] OP_MTLO  = 6'h18;
   localparam logic [5:0] OP_PASSA = 6'h19;
   localparam logic [5:0] OP_PASSB = 6'h1A;

   logic        unused_clk_rst;
   logic        slt_s;
   logic        slt_u;
   logic [4:0]  var_sh;
   logic [63:0] prod_s;
   logic [63:0] prod_u;
   logic        div_zero;
   logic        div_ovf;
   logic [31:0] quot_s;
   logic [31:0] rem_s;
   logic [31:0] quot_u;
   logic [31:0] rem_u;

   assign unused_clk_rst = &{1'b0, CLK, RESET};

   assign slt_s  = $signed(A) < $signed(B);
   assign slt_u  = A < B;
   assign var_sh = A[4:0];

   assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
   assign prod_u = {32'h0, A} * {32'h0, B};

   // Most-negative / -1 overflows a 32-bit signed quotient; pin it to the wrapped result.
   assign div_zero = (B == 32'h0);
   assign div_ovf  = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);

   always_comb begin
      quot_s = 32'h0;
      rem_s  = 32'h0;
      quot_u = 32'h0;
      rem_u  = 32'h0;
      if (div_ovf) begin
         quot_s = 32'h8000_0000;
         rem_s  = 32'h0;
      end else if (!div_zero) begin
         quot_s = $signed(A) / $signed(B);
         rem_s  = $signed(A) % $signed(B);
      end
      if (!div_zero) begin
         quot_u = A / B;
         rem_u  = A % B;
      end
   end

   always_comb begin
      aluResult = 32'h0;
      HI_OUT    = HI_IN;
      LO_OUT    = LO_IN;
      case (ALU_control)
         OP_ADD, OP_ADDU: aluResult = A + B;
         OP_SUB, OP_SUBU: aluResult = A - B;
         OP_AND:   aluResult = A & B;
         OP_OR:    aluResult = A | B;
         OP_XOR:   aluResult = A ^ B;
         OP_NOR:   aluResult = ~(A | B);
         OP_SLT:   aluResult = {31'h0, slt_s};
         OP_SLTU:  aluResult = {31'h0, slt_u};
         OP_SLL:   aluResult = B << shiftAmount;
         OP_SRL:   aluResult = B >> shiftAmount;
         OP_SRA:   aluResult = $unsigned($signed(B) >>> shiftAmount);
         OP_SLLV:  aluResult = B << var_sh;
         OP_SRLV:  aluResult = B >> var_sh;
         OP_SRAV:  aluResult = $unsigned($signed(B) >>> var_sh);
         OP_LUI:   aluResult = {B[15:0], 16'h0000};
         OP_MULT: begin
            HI_OUT = prod_s[63:32];
            LO_OUT = prod_s[31:0];
         end
         OP_MULTU: begin
            HI_OUT = prod_u[63:32];
            LO_OUT = prod_u[31:0];
         end
         OP_DIV: begin
            if (!div_zero) begin
               HI_OUT = rem_s;
               LO_OUT = quot_s;
            end
         end
         OP_DIVU: begin
            if (!div_zero) begin
               HI_OUT = rem_u;
               LO_OUT = quot_u;
            end
         end
         OP_MFHI:  aluResult = HI_IN;
         OP_MFLO:  aluResult = LO_IN;
         OP_MTHI:  HI_OUT = A;
         OP_MTLO:  LO_OUT = A;
         OP_PASSA: aluResult = A;
         OP_PASSB: aluResult = B;
         default:  aluResult = 32'h0;
      endcase
   end

endmodule

// File: tb/tb_alu_hilo.sv
// Directed-vector bench for alu_hilo: hand-computed results for every opcode class,
// divide corner cases, undefined opcodes and reset/clock independence.
module tb_alu_hilo;

   logic        CLK;
   logic        RESET;
   logic [31:0] A;
   logic [31:0] B;
   logic [5:0]  ALU_control;
   logic [4:0]  shiftAmount;
   logic [31:0] HI_IN;
   logic [31:0] LO_IN;
   logic [31:0] aluResult;
   logic [31:0] HI_OUT;
   logic [31:0] LO_OUT;

   int checks;
   int errors;

   alu_hilo dut (
      .CLK         (CLK),
      .RESET       (RESET),
      .A           (A),
      .B           (B),
      .ALU_control (ALU_control),
      .shiftAmount (shiftAmount),
      .HI_IN       (HI_IN),
      .LO_IN       (LO_IN),
      .aluResult   (aluResult),
      .HI_OUT      (HI_OUT),
      .LO_OUT      (LO_OUT)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
      end
   endtask

   task automatic apply(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] sh, input logic [31:0] hi, input logic [31:0] lo);
      ALU_control = op;
      A           = a;
      B           = b;
      shiftAmount = sh;
      HI_IN       = hi;
      LO_IN       = lo;
      #1;
   endtask

   task automatic check_all(input string tag, input logic [31:0] exp_res,
                            input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      check({tag, ".res"}, aluResult, exp_res);
      check({tag, ".hi"},  HI_OUT,    exp_hi);
      check({tag, ".lo"},  LO_OUT,    exp_lo);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      RESET  = 1'b0;
      apply(6'h00, 32'd2, 32'd3, 5'd0, 32'hC0DE_0001, 32'hC0DE_0002);

      // Outputs follow inputs through reset and after release.
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK);
         check_all("rst_add", 32'd5, 32'hC0DE_0001, 32'hC0DE_0002);
      end
      RESET = 1'b1;
      @(negedge CLK);
      check_all("post_rst_add", 32'd5, 32'hC0DE_0001, 32'hC0DE_0002);

      apply(6'h00, 32'h7FFF_FFFF, 32'h1, 5'd0, 32'h1, 32'h2);
      check_all("add_ovf", 32'h8000_0000, 32'h1, 32'h2);
      apply(6'h01, 32'hFFFF_FFFF, 32'h2, 5'd0, 32'h1, 32'h2);
      check("addu_wrap", aluResult, 32'h1);
      apply(6'h02, 32'h0, 32'h1, 5'd0, 32'h1, 32'h2);
      check("sub", aluResult, 32'hFFFF_FFFF);
      apply(6'h03, 32'd5, 32'd7, 5'd0, 32'h1, 32'h2);
      check("subu", aluResult, 32'hFFFF_FFFE);

      apply(6'h04, 32'hF0F0_00FF, 32'h0FF0_0F0F, 5'd0, 32'h1, 32'h2);
      check("and", aluResult, 32'h00F0_000F);
      apply(6'h05, 32'hF0F0_00FF, 32'h0FF0_0F0F, 5'd0, 32'h1, 32'h2);
      check("or", aluResult, 32'hFFF0_0FFF);
      apply(6'h06, 32'hF0F0_00FF, 32'h0FF0_0F0F, 5'd0, 32'h1, 32'h2);
      check("xor", aluResult, 32'hFF00_0FF0);
      apply(6'h07, 32'hF0F0_00FF, 32'h0FF0_0F0F, 5'd0, 32'h1, 32'h2);
      check("nor", aluResult, 32'h000F_F000);

      apply(6'h08, 32'hFFFF_FFFF, 32'h1, 5'd0, 32'h1, 32'h2);
      check("slt", aluResult, 32'h1);
      apply(6'h09, 32'hFFFF_FFFF, 32'h1, 5'd0, 32'h1, 32'h2);
      check("sltu", aluResult, 32'h0);

      apply(6'h0A, 32'h0, 32'h1, 5'd31, 32'h1, 32'h2);
      check("sll", aluResult, 32'h8000_0000);
      apply(6'h0B, 32'h0, 32'h8000_0000, 5'd4, 32'h1, 32'h2);
      check("srl", aluResult, 32'h0800_0000);
      apply(6'h0C, 32'h0, 32'h8000_0000, 5'd4, 32'h1, 32'h2);
      check("sra", aluResult, 32'hF800_0000);
      apply(6'h0D, 32'hFFFF_FFE4, 32'hF0, 5'd0, 32'h1, 32'h2);
      check("sllv", aluResult, 32'h0000_0F00);
      apply(6'h0E, 32'h24, 32'hF0, 5'd9, 32'h1, 32'h2);
      check("srlv", aluResult, 32'h0000_000F);
      apply(6'h0F, 32'h1F, 32'h8000_0000, 5'd0, 32'h1, 32'h2);
      check("srav", aluResult, 32'hFFFF_FFFF);
      apply(6'h10, 32'h0, 32'hABCD_1234, 5'd0, 32'h1, 32'h2);
      check("lui", aluResult, 32'h1234_0000);

      apply(6'h11, 32'hFFFF_FFFE, 32'd3, 5'd0, 32'h1, 32'h2);
      check_all("mult", 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
      apply(6'h12, 32'hFFFF_FFFE, 32'd3, 5'd0, 32'h1, 32'h2);
      check_all("multu", 32'h0, 32'h2, 32'hFFFF_FFFA);

      apply(6'h13, 32'hFFFF_FFF9, 32'd2, 5'd0, 32'h1, 32'h2);
      check_all("div_neg", 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      apply(6'h13, 32'd7, 32'hFFFF_FFFE, 5'd0, 32'h1, 32'h2);
      check_all("div_negb", 32'h0, 32'h1, 32'hFFFF_FFFD);
      apply(6'h13, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0, 32'h1, 32'h2);
      check_all("div_ovf", 32'h0, 32'h0, 32'h8000_0000);
      apply(6'h13, 32'd9, 32'h0, 5'd0, 32'hCC, 32'hDD);
      check_all("div_zero", 32'h0, 32'hCC, 32'hDD);
      apply(6'h14, 32'd7, 32'h0, 5'd0, 32'hAA, 32'hBB);
      check_all("divu_zero", 32'h0, 32'hAA, 32'hBB);
      apply(6'h14, 32'd100, 32'd7, 5'd0, 32'h1, 32'h2);
      check_all("divu", 32'h0, 32'd2, 32'd14);
      apply(6'h14, 32'hFFFF_FFFF, 32'd2, 5'd0, 32'h1, 32'h2);
      check_all("divu_big", 32'h0, 32'h1, 32'h7FFF_FFFF);

      apply(6'h15, 32'h0, 32'h0, 5'd0, 32'h11, 32'h66);
      check("mfhi", aluResult, 32'h11);
      apply(6'h16, 32'h0, 32'h0, 5'd0, 32'h11, 32'h66);
      check("mflo", aluResult, 32'h66);
      apply(6'h17, 32'h55, 32'h9, 5'd0, 32'h11, 32'h66);
      check_all("mthi", 32'h0, 32'h55, 32'h66);
      apply(6'h18, 32'h77, 32'h9, 5'd0, 32'h11, 32'h66);
      check_all("mtlo", 32'h0, 32'h11, 32'h77);
      apply(6'h19, 32'hDEAD_BEEF, 32'h1234_5678, 5'd0, 32'h11, 32'h66);
      check("passa", aluResult, 32'hDEAD_BEEF);
      apply(6'h1A, 32'hDEAD_BEEF, 32'h1234_5678, 5'd0, 32'h11, 32'h66);
      check("passb", aluResult, 32'h1234_5678);

      apply(6'h1B, 32'hDEAD_BEEF, 32'h1234_5678, 5'd3, 32'h11, 32'h66);
      check_all("undef_1b", 32'h0, 32'h11, 32'h66);
      apply(6'h3F, 32'hDEAD_BEEF, 32'h1234_5678, 5'd3, 32'h11, 32'h66);
      check_all("undef_3f", 32'h0, 32'h11, 32'h66);

      // Stable inputs across several clock edges must give stable outputs.
      apply(6'h11, 32'hFFFF_FFFE, 32'd3, 5'd0, 32'h1, 32'h2);
      for (int i = 0; i < 2; i++) begin
         @(negedge CLK);
         check_all("clk_hold", 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
